// File: rtl/speckle_frame_scanner.sv
// speckle_frame_scanner
// Walks a programmable rectangular window of a COLS x ROWS pixel RAM. The RAM
// read latency is RD_LAT cycles. Pixels stream out over a valid/ready
// interface with sof/eol/eof markers, in single-shot or continuous mode.
// Reads are credit limited, so the (RD_LAT+1)-entry output FIFO can never
// overflow. A read result is never dropped.
// Optional feature macro: SCAN_STATS_EN adds per-frame statistics: a count
// of pixels above i_umbral and the maximum pixel value. Without it,
// o_above_cnt and o_max are tied to 0.
module speckle_frame_scanner #(
  parameter int COLS        = 24,
  parameter int ROWS        = 24,
  parameter int NB_DATA     = 12,
  parameter int RD_LAT      = 1,
  parameter int NB_RAM_ADDR = $clog2(COLS*ROWS),
  parameter int NB_CNT      = $clog2(COLS*ROWS+1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic                       i_continuous,
  input  logic [$clog2(ROWS)-1:0]    i_row_first,
  input  logic [$clog2(ROWS)-1:0]    i_row_last,
  input  logic [$clog2(COLS)-1:0]    i_col_first,
  input  logic [$clog2(COLS)-1:0]    i_col_last,
  input  logic [NB_DATA-1:0]         i_umbral,
  output logic                       o_ram_en,
  output logic [NB_RAM_ADDR-1:0]     o_ram_addr,
  input  logic [NB_DATA-1:0]         i_ram_data,
  output logic [NB_DATA-1:0]         o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_sof,
  output logic                       o_eol,
  output logic                       o_eof,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err,
  output logic [NB_CNT-1:0]          o_above_cnt,
  output logic [NB_DATA-1:0]         o_max
);

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int DEPTH = RD_LAT + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CNTW  = $clog2(DEPTH + 1);
  localparam int UW    = CNTW + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } flags_t;

  // Sequencer state and latched window.
  state_t        state_q;
  logic [RW-1:0] row_q, row_first_q, row_last_q;
  logic [CW-1:0] col_q, col_first_q, col_last_q;
  logic          cont_q;
  logic          done_q;
  logic          err_q;

  // Read pipe: one valid bit and one set of markers per read in flight.
  logic [RD_LAT-1:0] pv_q;
  flags_t            pf_q [RD_LAT];

  // Output FIFO.
  logic [NB_DATA-1:0] fd_q [DEPTH];
  flags_t             ff_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]    fcnt_q;

  logic            fifo_valid;
  logic            push;
  logic            pop;
  logic [CNTW-1:0] inflight;
  logic [UW-1:0]   used;
  logic            can_issue;
  logic            win_bad;
  logic            eof_acc;
  flags_t          issue_flags;
  flags_t          head_flags;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Count the reads currently travelling through the RAM latency pipe.
  always_comb begin
    // NOTE: every variable driven here gets a value before any conditional
    // logic, so no latch can be inferred.
    inflight = '0;
    for (int k = 0; k < RD_LAT; k++) begin
      inflight = inflight + CNTW'(pv_q[k]);
    end
  end

  assign fifo_valid = (fcnt_q != '0);
  assign pop        = fifo_valid && i_ready;
  assign push       = pv_q[RD_LAT-1];
  assign head_flags = ff_q[rd_ptr_q];

  // A beat popped this cycle frees its slot in time for a read issued now.
  // This keeps one pixel per cycle under full throughput, and the FIFO still
  // holds every read that lands.
  assign used      = UW'(fcnt_q) + UW'(inflight) - UW'(pop);
  assign can_issue = (used < UW'(DEPTH));

  assign o_ram_en   = (state_q == SCAN) && can_issue && !i_abort;
  assign o_ram_addr = NB_RAM_ADDR'(32'(row_q) * COLS + 32'(col_q));

  assign issue_flags.sof = (row_q == row_first_q) && (col_q == col_first_q);
  assign issue_flags.eol = (col_q == col_last_q);
  assign issue_flags.eof = (col_q == col_last_q) && (row_q == row_last_q);

  assign win_bad = (i_row_first > i_row_last) || (i_col_first > i_col_last) ||
                   (32'(i_row_last) >= ROWS) || (32'(i_col_last) >= COLS);

  assign eof_acc = pop && head_flags.eof && !i_abort;

  // Sequencer: IDLE/SCAN/DRAIN, window walk, done and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all sequential state is assigned with <= so that every flop
    // samples values from before the clock edge.
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      row_first_q <= '0;
      row_last_q  <= '0;
      col_first_q <= '0;
      col_last_q  <= '0;
      cont_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (i_abort) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (i_start) begin
              if (win_bad) begin
                err_q <= 1'b1;
              end else begin
                row_first_q <= i_row_first;
                row_last_q  <= i_row_last;
                col_first_q <= i_col_first;
                col_last_q  <= i_col_last;
                cont_q      <= i_continuous;
                row_q       <= i_row_first;
                col_q       <= i_col_first;
                state_q     <= SCAN;
              end
            end
          end
          SCAN: begin
            if (o_ram_en) begin
              if (issue_flags.eof) begin
                state_q <= DRAIN;
              end else if (issue_flags.eol) begin
                row_q <= row_q + 1'b1;
                col_q <= col_first_q;
              end else begin
                col_q <= col_q + 1'b1;
              end
            end
          end
          DRAIN: begin
            if (eof_acc) begin
              done_q <= 1'b1;
              if (cont_q) begin
                row_q   <= row_first_q;
                col_q   <= col_first_q;
                state_q <= SCAN;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Markers travel with each read for RD_LAT cycles; an abort kills them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q <= '0;
      for (int k = 0; k < RD_LAT; k++) pf_q[k] <= '0;
    end else if (i_abort) begin
      pv_q <= '0;
    end else begin
      pv_q[0] <= o_ram_en;
      pf_q[0] <= issue_flags;
      for (int k = 1; k < RD_LAT; k++) begin
        pv_q[k] <= pv_q[k-1];
        pf_q[k] <= pf_q[k-1];
      end
    end
  end

  // FIFO pointers and occupancy; abort empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else if (i_abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      fcnt_q <= fcnt_q + CNTW'(push) - CNTW'(pop);
    end
  end

  // FIFO storage: capture the RAM word together with its markers.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; an entry is only read after it has been
    // written, and the outputs below are masked while the FIFO is empty.
    if (push) begin
      fd_q[wr_ptr_q] <= i_ram_data;
      ff_q[wr_ptr_q] <= pf_q[RD_LAT-1];
    end
  end

  assign o_valid = fifo_valid;
  assign o_data  = fifo_valid ? fd_q[rd_ptr_q] : '0;
  assign o_sof   = fifo_valid && head_flags.sof;
  assign o_eol   = fifo_valid && head_flags.eol;
  assign o_eof   = fifo_valid && head_flags.eof;
  assign o_busy  = (state_q != IDLE);
  assign o_done  = done_q;
  assign o_err   = err_q;

`ifdef SCAN_STATS_EN
  logic [NB_DATA-1:0] umbral_q;
  logic [NB_CNT-1:0]  run_cnt_q, run_cnt_d, above_q;
  logic [NB_DATA-1:0] run_max_q, run_max_d, max_q;
  logic [NB_DATA-1:0] head_data;
  logic               start_ok;

  assign head_data = fd_q[rd_ptr_q];
  assign start_ok  = (state_q == IDLE) && i_start && !i_abort && !win_bad;
  assign run_cnt_d = run_cnt_q + NB_CNT'(head_data > umbral_q);
  assign run_max_d = (head_data > run_max_q) ? head_data : run_max_q;

  // Running statistics per accepted beat, published on the eof handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      umbral_q  <= '0;
      run_cnt_q <= '0;
      run_max_q <= '0;
      above_q   <= '0;
      max_q     <= '0;
    end else if (!i_abort) begin
      if (start_ok) begin
        umbral_q  <= i_umbral;
        run_cnt_q <= '0;
        run_max_q <= '0;
      end else if (pop) begin
        if (head_flags.eof) begin
          above_q   <= run_cnt_d;
          max_q     <= run_max_d;
          run_cnt_q <= '0;
          run_max_q <= '0;
        end else begin
          run_cnt_q <= run_cnt_d;
          run_max_q <= run_max_d;
        end
      end
    end
  end

  assign o_above_cnt = above_q;
  assign o_max       = max_q;
`else
  logic unused_umbral;
  assign unused_umbral = ^i_umbral;
  assign o_above_cnt   = '0;
  assign o_max         = '0;
`endif

endmodule

// File: tb/tb_speckle_frame_scanner.sv
// Scoreboard bench for speckle_frame_scanner. The RAM is modelled with
// RD_LAT = 3. Expected frames come from nested window loops over the RAM
// contents and are queued when a frame is started. A negedge monitor pops
// the queue on each accepted beat and on each o_done pulse.
module tb_speckle_frame_scanner;
  localparam int COLS   = 24;
  localparam int ROWS   = 24;
  localparam int NB     = 12;
  localparam int RD_LAT = 3;
  localparam int NA     = $clog2(COLS*ROWS);
  localparam int NC     = $clog2(COLS*ROWS+1);
  localparam int RW     = $clog2(ROWS);
  localparam int CW     = $clog2(COLS);

  logic          clk, rst;
  logic          i_start, i_abort, i_continuous, i_ready;
  logic [RW-1:0] i_row_first, i_row_last;
  logic [CW-1:0] i_col_first, i_col_last;
  logic [NB-1:0] i_umbral, i_ram_data, o_data, o_max;
  logic          o_ram_en, o_valid, o_sof, o_eol, o_eof, o_busy, o_done, o_err;
  logic [NA-1:0] o_ram_addr;
  logic [NC-1:0] o_above_cnt;

  speckle_frame_scanner #(.COLS(COLS), .ROWS(ROWS), .NB_DATA(NB), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_continuous(i_continuous), .i_row_first(i_row_first), .i_row_last(i_row_last),
    .i_col_first(i_col_first), .i_col_last(i_col_last), .i_umbral(i_umbral),
    .o_ram_en(o_ram_en), .o_ram_addr(o_ram_addr), .i_ram_data(i_ram_data),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_sof(o_sof),
    .o_eol(o_eol), .o_eof(o_eof), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_above_cnt(o_above_cnt), .o_max(o_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel RAM model with RD_LAT cycles of read latency.
  logic [NB-1:0] ram_mem [COLS*ROWS];
  logic [NA-1:0] rd_addr_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_addr_pipe[0] <= o_ram_addr;
    for (int k = 1; k < RD_LAT; k++) rd_addr_pipe[k] <= rd_addr_pipe[k-1];
  end
  assign i_ram_data = ram_mem[rd_addr_pipe[RD_LAT-1]];

  typedef struct {
    logic [NB-1:0] d;
    logic sof, eol, eof;
  } beat_t;
  typedef struct {
    int above;
    int mx;
  } stats_t;

  beat_t  exp_q[$];
  stats_t stat_q[$];
  int     tests = 0, fails = 0;
  int     w_rf, w_rl, w_cf, w_cl, w_umb;
  bit     cont_active = 0;
  int     rdy_mode = 0;
  int     beat_cnt = 0, done_cnt = 0;
  int     issued = 0, accepted = 0, max_out = 0;
  int     last_above = 0, last_max = 0;
  logic   prev_stall = 0, prev_eof_hs = 0;
  logic [15:0] prev_word = '0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the window in row-major order straight from the RAM image.
  function automatic void push_frame();
    int    above = 0, mx = 0;
    beat_t b;
    stats_t s;
    for (int r = w_rf; r <= w_rl; r++) begin
      for (int c = w_cf; c <= w_cl; c++) begin
        b.d   = ram_mem[r*COLS + c];
        b.sof = (r == w_rf) && (c == w_cf);
        b.eol = (c == w_cl);
        b.eof = (c == w_cl) && (r == w_rl);
        exp_q.push_back(b);
        if (int'(b.d) > w_umb) above++;
        if (int'(b.d) > mx) mx = int'(b.d);
      end
    end
`ifdef SCAN_STATS_EN
    s.above = above;
    s.mx    = mx;
`else
    s.above = 0;
    s.mx    = 0;
`endif
    stat_q.push_back(s);
  endfunction

  // Ready driver: 0 = always ready, 1 = low about 30% of cycles.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = ($urandom_range(0, 99) >= 30);
      default: i_ready = 1'b0;
    endcase
  end

  // Monitor: compares every accepted beat and every done pulse.
  always @(negedge clk) begin
    beat_t  e;
    stats_t s;
    logic   hs;
    if (rst) begin
      prev_stall  = 1'b0;
      prev_eof_hs = 1'b0;
      issued      = 0;
      accepted    = 0;
    end else begin
      hs = o_valid && i_ready && !i_abort;
      if (prev_stall)
        check("stall_hold", longint'({o_valid, o_data, o_sof, o_eol, o_eof}), longint'(prev_word));
      if (o_ram_en && !i_abort) issued++;
      if (hs) begin
        accepted++;
        beat_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", o_data, e.d);
          check("beat_flags", {o_sof, o_eol, o_eof}, {e.sof, e.eol, e.eof});
        end
      end
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (o_done || prev_eof_hs) check("done_timing", o_done, prev_eof_hs);
      if (o_done) begin
        done_cnt++;
        if (stat_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          s = stat_q.pop_front();
          check("stat_above", o_above_cnt, s.above);
          check("stat_max", o_max, s.mx);
          last_above = s.above;
          last_max   = s.mx;
        end
        if (cont_active) begin
          check("cont_restart", {o_ram_en, o_ram_addr}, {1'b1, NA'(w_rf*COLS + w_cf)});
          push_frame();
        end
      end
      prev_eof_hs = hs && o_eof;
      prev_stall  = o_valid && !i_ready && !i_abort;
      prev_word   = {o_valid, o_data, o_sof, o_eol, o_eof};
      if (i_abort) begin
        issued   = 0;
        accepted = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_window(input int rf, input int rl, input int cf, input int cl, input int umb);
    i_row_first = RW'(rf);
    i_row_last  = RW'(rl);
    i_col_first = CW'(cf);
    i_col_last  = CW'(cl);
    i_umbral    = NB'(umb);
  endtask

  // One single-shot frame: queue the expectation, pulse start, check timing.
  task automatic run_frame(input int rf, input int rl, input int cf, input int cl,
                           input int umb, input int mode);
    int n, npix, d0;
    rdy_mode = mode;
    cont_active = 0;
    w_rf = rf; w_rl = rl; w_cf = cf; w_cl = cl; w_umb = umb;
    push_frame();
    npix = (rl - rf + 1) * (cl - cf + 1);
    d0 = done_cnt;
    drive_window(rf, rl, cf, cl, umb);
    i_continuous = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("start_busy", o_busy, 1);
    check("start_read", {o_ram_en, o_ram_addr}, {1'b1, NA'(rf*COLS + cf)});
    n = 1;
    while (!o_valid && n < 100) begin tick(); n++; end
    check("first_valid_cycle", n, RD_LAT + 2);
    while (!o_done && n < 5000) begin tick(); n++; end
    if (n >= 5000) check("frame_timeout", 0, 1);
    else if (mode == 0) check("frame_end_cycle", n, RD_LAT + npix + 2);
    tick();
    tick();
    check("frame_queue_empty", exp_q.size(), 0);
    check("done_once", done_cnt - d0, 1);
    check("idle_after_frame", {o_valid, o_busy}, 0);
  endtask

  task automatic err_start(input int rf, input int rl, input int cf, input int cl);
    drive_window(rf, rl, cf, cl, 0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("err_pulse", {o_err, o_busy, o_ram_en}, 3'b100);
    tick();
    check("err_after", {o_err, o_busy, o_ram_en, o_valid}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0, la, lm, rf, rl, cf, cl;
    rst = 1'b1;
    i_start = 1'b0; i_abort = 1'b0; i_continuous = 1'b0; i_ready = 1'b1;
    drive_window(0, 0, 0, 0, 0);
    for (int a = 0; a < COLS*ROWS; a++) ram_mem[a] = NB'(a);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {o_ram_en, o_ram_addr, o_data, o_valid, o_sof, o_eol, o_eof,
                            o_busy, o_done, o_err, o_above_cnt, o_max}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Full array, addr->addr, threshold 1, always ready.
    run_frame(0, ROWS-1, 0, COLS-1, 1, 0);
`ifdef SCAN_STATS_EN
    check("full_above", o_above_cnt, 574);
    check("full_max", o_max, 575);
`else
    check("full_above", o_above_cnt, 0);
    check("full_max", o_max, 0);
`endif

    // Small interior window: data 53..55, 77..79, 101..103.
    run_frame(2, 4, 5, 7, 60, 0);

    // Full array under random backpressure.
    max_out = 0;
    run_frame(0, ROWS-1, 0, COLS-1, 300, 1);

    // Illegal windows.
    err_start(0, 5, 10, 3);
    err_start(0, 24, 0, 5);
    err_start(6, 2, 0, 0);

    // Abort at beat 100 of a full scan, then a clean frame.
    rdy_mode = 0;
    w_rf = 0; w_rl = ROWS-1; w_cf = 0; w_cl = COLS-1; w_umb = 0;
    push_frame();
    drive_window(0, ROWS-1, 0, COLS-1, 0);
    beat_cnt = 0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n = 0;
    while (beat_cnt < 100 && n < 2000) begin tick(); n++; end
    check("abort_reached_beat", beat_cnt >= 100, 1);
    la = last_above; lm = last_max; d0 = done_cnt;
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    exp_q.delete();
    stat_q.delete();
    check("abort_valid", o_valid, 0);
    check("abort_busy", o_busy, 0);
    repeat (8) tick();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_stats_above", o_above_cnt, la);
    check("abort_stats_max", o_max, lm);
    run_frame(0, ROWS-1, 0, COLS-1, 200, 0);

    // Single-pixel window in the far corner.
    run_frame(ROWS-1, ROWS-1, COLS-1, COLS-1, 0, 0);

    // Random windows, RAM contents and thresholds.
    for (int t = 0; t < 6; t++) begin
      for (int a = 0; a < COLS*ROWS; a++) ram_mem[a] = NB'($urandom_range(0, 4095));
      rf = $urandom_range(0, ROWS-1);
      rl = $urandom_range(rf, ROWS-1);
      cf = $urandom_range(0, COLS-1);
      cl = $urandom_range(cf, COLS-1);
      run_frame(rf, rl, cf, cl, $urandom_range(0, 4095), $urandom_range(0, 1));
    end

    // Continuous 2x2; window inputs changed mid-scan must be ignored.
    rdy_mode = 0;
    w_rf = 1; w_rl = 2; w_cf = 3; w_cl = 4; w_umb = 2000;
    cont_active = 1;
    push_frame();
    drive_window(1, 2, 3, 4, 2000);
    i_continuous = 1'b1;
    d0 = done_cnt;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_continuous = 1'b0;
    drive_window(0, 10, 0, 10, 0);
    n = 0;
    while (done_cnt < d0 + 3 && n < 500) begin tick(); n++; end
    check("cont_three_frames", done_cnt - d0 >= 3, 1);
    tick();
    tick();
    check("cont_still_busy", o_busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {o_ram_en, o_ram_addr, o_data, o_valid, o_sof, o_eol, o_eof,
                                  o_busy, o_done, o_err, o_above_cnt, o_max}, 0);
    cont_active = 0;
    exp_q.delete();
    stat_q.delete();
    last_above = 0;
    last_max = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Recovery after reset.
    run_frame(5, 5, 0, 2, 1000, 0);

    check("max_outstanding_le_depth", max_out <= RD_LAT + 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
